// File: rtl/pipe_stage_skid.sv
// Pipeline-boundary register with a two-entry skid buffer.
// Carries inst/pc/err across a stage boundary using valid/ready handshakes.
// The head register drives the outputs directly; the skid register absorbs one
// entry when downstream stalls in the same cycle an entry is accepted, so
// in_ready can be a flop with no combinational path from out_ready.
module pipe_stage_skid #(
  parameter int unsigned       DATA_W  = 16,
  parameter int unsigned       PC_W    = 16,
  parameter int unsigned       ERR_W   = 1,
  parameter logic [DATA_W-1:0] NOP_VAL = DATA_W'(16'b0000_1000_0000_0000),
  parameter int unsigned       CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_inst,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [ERR_W-1:0]  in_err,
  input  logic              in_kill,

  input  logic              flush,

  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_inst,
  output logic [PC_W-1:0]   out_pc,
  output logic [ERR_W-1:0]  out_err,

  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic              in_ready_q;
  logic              out_valid_q;

  logic [DATA_W-1:0] head_inst_q, head_inst_d;
  logic [PC_W-1:0]   head_pc_q,   head_pc_d;
  logic [ERR_W-1:0]  head_err_q,  head_err_d;

  logic [DATA_W-1:0] skid_inst_q, skid_inst_d;
  logic [PC_W-1:0]   skid_pc_q,   skid_pc_d;
  logic [ERR_W-1:0]  skid_err_q,  skid_err_d;

  logic [CNT_W-1:0]  stall_cnt_q;

  logic              accept;
  logic              consume;
  logic              stalled;
  logic [DATA_W-1:0] ent_inst;
  logic [ERR_W-1:0]  ent_err;

  assign accept  = in_valid & in_ready_q;
  assign consume = out_valid_q & out_ready;
  assign stalled = out_valid_q & ~out_ready;

  // Killed entries stay valid but carry a NOP and no error flags.
  assign ent_inst = in_kill ? NOP_VAL : in_inst;
  assign ent_err  = in_kill ? '0 : in_err;

  // Next-state and storage selection for the head/skid pair.
  always_comb begin
    state_d     = state_q;
    head_inst_d = head_inst_q;
    head_pc_d   = head_pc_q;
    head_err_d  = head_err_q;
    skid_inst_d = skid_inst_q;
    skid_pc_d   = skid_pc_q;
    skid_err_d  = skid_err_q;

    case (state_q)
      StEmpty: begin
        if (accept) begin
          state_d     = StOne;
          head_inst_d = ent_inst;
          head_pc_d   = in_pc;
          head_err_d  = ent_err;
        end
      end
      StOne: begin
        if (accept && consume) begin
          head_inst_d = ent_inst;
          head_pc_d   = in_pc;
          head_err_d  = ent_err;
        end else if (accept) begin
          state_d     = StFull;
          skid_inst_d = ent_inst;
          skid_pc_d   = in_pc;
          skid_err_d  = ent_err;
        end else if (consume) begin
          // Head becomes invalid: present a NOP, keep the last PC visible.
          state_d     = StEmpty;
          head_inst_d = NOP_VAL;
          head_err_d  = '0;
        end
      end
      StFull: begin
        if (consume) begin
          state_d     = StOne;
          head_inst_d = skid_inst_q;
          head_pc_d   = skid_pc_q;
          head_err_d  = skid_err_q;
        end
      end
      default: begin
        state_d     = StEmpty;
        head_inst_d = NOP_VAL;
        head_err_d  = '0;
      end
    endcase

    // Flush drops held and offered entries; PC is left untouched.
    if (flush) begin
      state_d     = StEmpty;
      head_inst_d = NOP_VAL;
      head_pc_d   = head_pc_q;
      head_err_d  = '0;
    end
  end

  // State, storage and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StEmpty;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      head_inst_q <= NOP_VAL;
      head_pc_q   <= '0;
      head_err_q  <= '0;
      skid_inst_q <= '0;
      skid_pc_q   <= '0;
      skid_err_q  <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != StFull);
      out_valid_q <= (state_d != StEmpty);
      head_inst_q <= head_inst_d;
      head_pc_q   <= head_pc_d;
      head_err_q  <= head_err_d;
      skid_inst_q <= skid_inst_d;
      skid_pc_q   <= skid_pc_d;
      skid_err_q  <= skid_err_d;
    end
  end

  // Saturating back-pressure counter; clear wins over increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (cnt_clr) begin
      stall_cnt_q <= '0;
    end else if (stalled && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_inst  = head_inst_q;
  assign out_pc    = head_pc_q;
  assign out_err   = head_err_q;
  assign stall_cnt = stall_cnt_q;

endmodule
